// File: rtl/neuron_mac_seq_if.sv
// Handshake/bus bundle for one neuron MAC sequencer: weight BRAM read port,
// activation input stream, result output stream and start/busy control.
interface neuron_mac_seq_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16
);
  logic              START;
  logic              BUSY;
  logic [ADDR_W-1:0] W_ADDR;
  logic              W_EN;
  logic              W_WE;
  logic [DATA_W-1:0] W_DO;
  logic [DATA_W-1:0] X_DATA;
  logic              X_VALID;
  logic              X_READY;
  logic [DATA_W-1:0] Y_DATA;
  logic              Y_VALID;
  logic              Y_READY;

  modport master (
    input  START, W_DO, X_DATA, X_VALID, Y_READY,
    output BUSY, W_ADDR, W_EN, W_WE, X_READY, Y_DATA, Y_VALID
  );

  modport slave (
    output START, W_DO, X_DATA, X_VALID, Y_READY,
    input  BUSY, W_ADDR, W_EN, W_WE, X_READY, Y_DATA, Y_VALID
  );
endinterface

// File: rtl/neuron_mac_seq.sv
// Single-neuron multiply-accumulate sequencer: walks the weight BRAM, MACs
// streamed activations, adds bias, rescales, saturates and optionally ReLUs.
module neuron_mac_seq #(
  parameter int unsigned N_IN      = 28,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned ACC_W     = 40,
  parameter int          BIAS      = 0,
  parameter bit          RELU      = 1'b1
) (
  input  logic                CLK,
  input  logic                RST_N,
  neuron_mac_seq_if.master    bus
);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, FINAL, OUT} state_t;

  localparam logic [ADDR_W-1:0]       LAST     = ADDR_W'(N_IN - 1);
  localparam logic [DATA_W-1:0]       BIAS_W   = DATA_W'(BIAS);
  localparam logic signed [ACC_W-1:0] BIAS_ACC =
    {{(ACC_W-DATA_W){BIAS_W[DATA_W-1]}}, BIAS_W} <<< FRAC_BITS;
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                    state, state_next;
  logic [ADDR_W-1:0]         idx, idx_next;
  logic signed [ACC_W-1:0]   acc, acc_next;
  logic                      w_en, w_en_next;
  logic                      x_ready, x_ready_next;
  logic                      y_valid, y_valid_next;
  logic [DATA_W-1:0]         y_data, y_data_next;

  logic                      hs;
  logic signed [2*DATA_W-1:0] x_ext, w_ext, prod;
  logic signed [ACC_W-1:0]   prod_ext, sum, shifted;
  logic [DATA_W-1:0]         result;

  assign hs = bus.X_VALID & x_ready;

  // Operands widened first so the 32-bit product is the exact signed product.
  assign x_ext    = {{DATA_W{bus.X_DATA[DATA_W-1]}}, bus.X_DATA};
  assign w_ext    = {{DATA_W{bus.W_DO[DATA_W-1]}}, bus.W_DO};
  assign prod     = x_ext * w_ext;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  assign sum     = acc + BIAS_ACC;
  assign shifted = sum >>> FRAC_BITS;

  always_comb begin
    if (shifted > SAT_MAX)      result = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shifted < SAT_MIN) result = {1'b1, {(DATA_W-1){1'b0}}};
    else                        result = shifted[DATA_W-1:0];
    if (RELU && result[DATA_W-1]) result = '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      idx     <= '0;
      acc     <= '0;
      w_en    <= 1'b0;
      x_ready <= 1'b0;
      y_valid <= 1'b0;
      y_data  <= '0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      acc     <= acc_next;
      w_en    <= w_en_next;
      x_ready <= x_ready_next;
      y_valid <= y_valid_next;
      y_data  <= y_data_next;
    end
  end

  always_comb begin
    state_next   = state;
    idx_next     = idx;
    acc_next     = acc;
    w_en_next    = w_en;
    x_ready_next = x_ready;
    y_valid_next = y_valid;
    y_data_next  = y_data;
    case (state)
      IDLE: begin
        if (bus.START) begin
          acc_next   = '0;
          idx_next   = '0;
          w_en_next  = 1'b1;
          state_next = PRIME;
        end
      end
      PRIME: begin
        x_ready_next = 1'b1;
        state_next   = RUN;
      end
      RUN: begin
        // The address only moves on a handshake, so W_DO stays valid across stalls.
        if (hs) begin
          acc_next = acc + prod_ext;
          if (idx == LAST) begin
            x_ready_next = 1'b0;
            state_next   = FINAL;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      FINAL: begin
        y_data_next  = result;
        y_valid_next = 1'b1;
        w_en_next    = 1'b0;
        state_next   = OUT;
      end
      OUT: begin
        if (bus.Y_READY) begin
          y_valid_next = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.BUSY    = (state != IDLE);
  assign bus.W_ADDR  = idx;
  assign bus.W_EN    = w_en;
  assign bus.W_WE    = 1'b0;
  assign bus.X_READY = x_ready;
  assign bus.Y_DATA  = y_data;
  assign bus.Y_VALID = y_valid;

endmodule
